serial_rx_ctrl: RTL and testbench

Control and capture stage for the `cntshiftQ` serial-to-parallel datapath. It monitors the serial line for a start bit, then drives the shift-register and counter controls (`ld`, `init_sh`, `en_sh`, `en_cnt`, `rst_sh`, `rst_cnt`) for one frame. When the datapath raises `co`, it captures `PO_sh` into an output register and presents the word on a valid/ready handshake. It sits between the serial pin and any word-level consumer.

---
 rtl/serial_rx_pkg.sv | 58 +++++
 rtl/rx_watchdog.sv | 29 ++
 rtl/serial_rx_ctrl.sv | 114 +++++++++++
 tb/tb_serial_rx_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial receive controller.
// The StParity state is only reachable when SERIAL_RX_PARITY_EN is defined.
package serial_rx_pkg;

    localparam int unsigned DefaultDw      = 8;
    localparam int unsigned DefaultMaxWait = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StAbort,
        StParity
    } rx_state_t;

    typedef struct packed {
        logic ld;
        logic init_sh;
        logic en_sh;
        logic en_cnt;
        logic rst_sh;
        logic rst_cnt;
        logic timeout;
        logic busy;
    } rx_ctrl_t;

    // Control pattern to present while the FSM sits in state s.
    function automatic rx_ctrl_t ctrl_for(rx_state_t s);
        rx_ctrl_t c;
        c      = '0;
        c.busy = (s != StIdle);
        case (s)
            StIdle: begin
                c.ld      = 1'b1;
                c.init_sh = 1'b1;
            end
            StLoad: begin
                c.ld      = 1'b1;
                c.init_sh = 1'b1;
                c.en_sh   = 1'b1;
                c.en_cnt  = 1'b1;
            end
            StShift: begin
                c.en_sh  = 1'b1;
                c.en_cnt = 1'b1;
            end
            StAbort: begin
                c.rst_sh  = 1'b1;
                c.rst_cnt = 1'b1;
                c.timeout = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rx_watchdog.sv
// Saturating wait counter that flags the MAX_WAIT-th ticked cycle of a frame.
module rx_watchdog #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != CntW'(MAX_WAIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High on the tick that brings the count to MAX_WAIT.
    assign expired = tick && (cnt_q >= CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/serial_rx_ctrl.sv
// Frame controller and capture register for the cntshiftQ serial-to-parallel datapath.
// Optional even-parity check enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int unsigned DW       = DefaultDw,
    parameter int unsigned MAX_WAIT = DefaultMaxWait
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          si,
    input  logic          co,
    input  logic [DW-1:0] PO_sh,
    output logic          ld,
    output logic          init_sh,
    output logic          en_sh,
    output logic          en_cnt,
    output logic          rst_sh,
    output logic          rst_cnt,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          overrun,
    output logic          timeout,
    output logic          busy
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic          parity_err
`endif
);

    rx_state_t state_q, state_d;
    rx_ctrl_t  ctrl_q;
    logic      expired;

    rx_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == StLoad),
        .tick   (state_q == StShift),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (si) state_d = StLoad;
            StLoad:    state_d = StShift;
            StShift: begin
                // Carry-out takes priority over a simultaneous watchdog expiry.
                if (co) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StCapture;
`endif
                end else if (expired) begin
                    state_d = StAbort;
                end
            end
            StParity:  state_d = StCapture;
            StCapture: state_d = StIdle;
            StAbort:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_bit_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ctrl_q     <= ctrl_for(StIdle);
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
            // PO_sh is frozen during CAPTURE since the shift enable is already low.
            if (state_q == StCapture) begin
                data_out   <= PO_sh;
                data_valid <= 1'b1;
                if (data_valid && !data_ready) overrun <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                parity_err <= ^PO_sh ^ par_bit_q;
`endif
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
`ifdef SERIAL_RX_PARITY_EN
            if (state_q == StParity) par_bit_q <= si;
`endif
        end
    end

    assign ld      = ctrl_q.ld;
    assign init_sh = ctrl_q.init_sh;
    assign en_sh   = ctrl_q.en_sh;
    assign en_cnt  = ctrl_q.en_cnt;
    assign rst_sh  = ctrl_q.rst_sh;
    assign rst_cnt = ctrl_q.rst_cnt;
    assign timeout = ctrl_q.timeout;
    assign busy    = ctrl_q.busy;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Randomized bench for serial_rx_ctrl; each frame is planned up front and expected
// outputs follow from the cycle offset within that frame.
module tb_serial_rx_ctrl;

    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_WAIT = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int ParLen = 1;
`else
    localparam int ParLen = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, si, co, data_ready;
    logic [DW-1:0] PO_sh;
    logic          ld, init_sh, en_sh, en_cnt, rst_sh, rst_cnt;
    logic [DW-1:0] data_out;
    logic          data_valid, overrun, timeout, busy;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    serial_rx_ctrl #(
        .DW      (DW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .si        (si),
        .co        (co),
        .PO_sh     (PO_sh),
        .ld        (ld),
        .init_sh   (init_sh),
        .en_sh     (en_sh),
        .en_cnt    (en_cnt),
        .rst_sh    (rst_sh),
        .rst_cnt   (rst_cnt),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .overrun   (overrun),
        .timeout   (timeout),
        .busy      (busy)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Frame plan: offset 0 is the load cycle, 1..len the shift cycles, then the
    // tail (parity/capture or abort) up to end_off, after which the line is idle.
    int          fr_off   = -1;
    int          frame_no = 0;
    int          co_delay = 0;
    int          len      = 0;
    int          end_off  = 0;
    bit          cap      = 1'b0;
    logic [DW-1:0] m_data;
    bit          m_valid, m_ov;
`ifdef SERIAL_RX_PARITY_EN
    bit          m_perr, par_bit;
`endif

    task automatic model_reset();
        fr_off  = -1;
        m_data  = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        m_perr  = 1'b0;
`endif
    endtask

    task automatic plan_frame();
        case (frame_no)
            0:       co_delay = 8;
            1:       co_delay = 20;
            2:       co_delay = MAX_WAIT;
            3:       co_delay = 1;
            6:       co_delay = 10;
            default: co_delay = int'($urandom_range(1, MAX_WAIT + 2));
        endcase
        cap     = (co_delay <= MAX_WAIT);
        len     = cap ? co_delay : MAX_WAIT;
        end_off = cap ? len + 1 + ParLen : len + 1;
    endtask

    // {ld, init_sh, en_sh, en_cnt, rst_sh, rst_cnt, timeout, busy}
    function automatic logic [7:0] exp_ctrl();
        if (fr_off < 0)    return 8'b1100_0000;
        if (fr_off == 0)   return 8'b1111_0001;
        if (fr_off <= len) return 8'b0011_0001;
        if (!cap)          return 8'b0000_1111;
        return 8'b0000_0001;
    endfunction

    task automatic model_edge();
        bit capture_now;
        capture_now = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            if (fr_off < 0) begin
                if (si) begin
                    fr_off = 0;
                    plan_frame();
                end
            end else if (fr_off == end_off) begin
                capture_now = cap;
                fr_off      = -1;
                frame_no++;
            end else begin
`ifdef SERIAL_RX_PARITY_EN
                if (cap && fr_off == len + 1) par_bit = si;
`endif
                fr_off++;
            end
            if (capture_now) begin
                if (m_valid && !data_ready) m_ov = 1'b1;
                m_data  = PO_sh;
                m_valid = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                m_perr  = ^PO_sh ^ par_bit;
`endif
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check("ctrl", 32'({ld, init_sh, en_sh, en_cnt, rst_sh, rst_cnt, timeout, busy}),
              32'(exp_ctrl()));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("overrun", 32'(overrun), 32'(m_ov));
`ifdef SERIAL_RX_PARITY_EN
        if (m_valid) check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    endtask

    task automatic drive(input int cyc);
        logic [7:0] pat;
        pat        = 8'hB2;
        data_ready = (cyc < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        co         = ($urandom_range(0, 1) == 1);
        si         = ($urandom_range(0, 1) == 1);
        PO_sh      = DW'($urandom);
        if (fr_off < 0) begin
            si = (cyc >= 10) && ($urandom_range(0, 2) == 0);
        end else begin
            if (fr_off >= 1 && fr_off <= len) co = (fr_off == co_delay);
            if (frame_no == 0) begin
                PO_sh = pat;
                if (fr_off >= 1 && fr_off <= 8) si = pat[8-fr_off];
                if (fr_off == len + 1) si = 1'b1;
            end
        end
        if (frame_no == 6 && fr_off == 3 && rst) begin
            rst = 1'b0;
            #1;
            check("async_rst_ctrl",
                  32'({ld, init_sh, en_sh, en_cnt, rst_sh, rst_cnt, timeout, busy,
                       data_valid, overrun}), 32'(10'b11_0000_0000));
            check("async_rst_data", 32'(data_out), 32'd0);
            model_reset();
            frame_no++;
        end
    endtask

    initial begin
        rst        = 1'b0;
        si         = 1'b0;
        co         = 1'b0;
        data_ready = 1'b0;
        PO_sh      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!rst) rst = 1'b1;
            check_all();
            drive(cyc);
            @(posedge clk);
            model_edge();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
